// File: rtl/bram_stream_pkg.sv
// Shared field layout and FSM encoding for the BRAM stream descriptor/instruction path.
// Used by bram_instr_gen (instruction producer) and the bram_stream_s instruction decode.
package bram_stream_pkg;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned LEN_W   = 13;
  localparam int unsigned ROWS_W  = 12;
  localparam int unsigned DESC_W  = 64;
  localparam int unsigned INSTR_W = 64;

  // Descriptor: {13'b0, rows[50:39], stride[38:26], len[25:13], base[12:0]}
  localparam int unsigned DESC_BASE_LSB   = 0;
  localparam int unsigned DESC_LEN_LSB    = 13;
  localparam int unsigned DESC_STRIDE_LSB = 26;
  localparam int unsigned DESC_ROWS_LSB   = 39;
  localparam int unsigned DESC_USED_W     = 51;

  // Instruction: {38'b0, addr[25:13], len[12:0]}
  localparam int unsigned INSTR_LEN_LSB  = 0;
  localparam int unsigned INSTR_ADDR_LSB = 13;
  localparam int unsigned INSTR_PAD_W    = INSTR_W - ADDR_W - LEN_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } gen_state_e;

  function automatic logic [INSTR_W-1:0] pack_instr(input logic [ADDR_W-1:0] addr,
                                                    input logic [LEN_W-1:0]  len);
    return {{INSTR_PAD_W{1'b0}}, addr, len};
  endfunction

endpackage

// File: rtl/bram_instr_gen.sv
// Expands one 2-D tile descriptor into one AXI-Stream instruction per row.
// Define BRAM_INSTR_GEN_STATS_EN to add instr_count/desc_count statistics outputs.
module bram_instr_gen
  import bram_stream_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DESC_W-1:0]  s_desc_tdata,
  input  logic               s_desc_tvalid,
  output logic               s_desc_tready,
  output logic [INSTR_W-1:0] m_instruct_tdata,
  output logic               m_instruct_tvalid,
  input  logic               m_instruct_tready,
  output logic               busy,
  output logic               done
`ifdef BRAM_INSTR_GEN_STATS_EN
  ,
  output logic [31:0]        instr_count,
  output logic [31:0]        desc_count
`endif
);

  gen_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  len_q;
  logic [ROWS_W-1:0] row_cnt_q;

  logic              desc_hs;
  logic              instr_hs;
  logic [ADDR_W-1:0] desc_base;
  logic [ADDR_W-1:0] desc_stride;
  logic [LEN_W-1:0]  desc_len;
  logic [ROWS_W-1:0] desc_rows;
  logic              unused_desc_bits;

  assign desc_hs     = s_desc_tvalid & s_desc_tready;
  assign instr_hs    = m_instruct_tvalid & m_instruct_tready;
  assign desc_base   = s_desc_tdata[DESC_BASE_LSB +: ADDR_W];
  assign desc_len    = s_desc_tdata[DESC_LEN_LSB +: LEN_W];
  assign desc_stride = s_desc_tdata[DESC_STRIDE_LSB +: ADDR_W];
  assign desc_rows   = s_desc_tdata[DESC_ROWS_LSB +: ROWS_W];
  assign unused_desc_bits = ^s_desc_tdata[DESC_W-1:DESC_USED_W];

  // tdata comes straight from the address/length flops, so it is stable while stalled.
  assign m_instruct_tdata = pack_instr(addr_q, len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      s_desc_tready     <= 1'b1;
      m_instruct_tvalid <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      addr_q            <= '0;
      stride_q          <= '0;
      len_q             <= '0;
      row_cnt_q         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (desc_hs) begin
            addr_q        <= desc_base;
            stride_q      <= desc_stride;
            len_q         <= desc_len;
            row_cnt_q     <= desc_rows;
            s_desc_tready <= 1'b0;
            if (desc_rows == '0 || desc_len == '0) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              m_instruct_tvalid <= 1'b1;
              busy              <= 1'b1;
              state_q           <= StIssue;
            end
          end
        end
        StIssue: begin
          if (instr_hs) begin
            addr_q    <= addr_q + stride_q;
            row_cnt_q <= row_cnt_q - 1'b1;
            if (row_cnt_q == ROWS_W'(1)) begin
              m_instruct_tvalid <= 1'b0;
              busy              <= 1'b0;
              done              <= 1'b1;
              state_q           <= StDone;
            end
          end
        end
        StDone: begin
          s_desc_tready <= 1'b1;
          state_q       <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef BRAM_INSTR_GEN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      desc_count  <= '0;
    end else begin
      if (instr_hs) instr_count <= instr_count + 32'd1;
      if (desc_hs)  desc_count  <= desc_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_instr_gen.sv
// Randomized self-checking bench for bram_instr_gen against a per-row address model.
// Build with BRAM_INSTR_GEN_STATS_EN defined to also check the statistics counters.
module tb_bram_instr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_desc_tdata;
  logic        s_desc_tvalid;
  logic        s_desc_tready;
  logic [63:0] m_instruct_tdata;
  logic        m_instruct_tvalid;
  logic        m_instruct_tready;
  logic        busy;
  logic        done;
`ifdef BRAM_INSTR_GEN_STATS_EN
  logic [31:0] instr_count;
  logic [31:0] desc_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned mdl_desc  = 0;
  int unsigned mdl_instr = 0;

  always #5 clk = ~clk;

  bram_instr_gen dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_desc_tdata      (s_desc_tdata),
    .s_desc_tvalid     (s_desc_tvalid),
    .s_desc_tready     (s_desc_tready),
    .m_instruct_tdata  (m_instruct_tdata),
    .m_instruct_tvalid (m_instruct_tvalid),
    .m_instruct_tready (m_instruct_tready),
    .busy              (busy),
    .done              (done)
`ifdef BRAM_INSTR_GEN_STATS_EN
    ,
    .instr_count       (instr_count),
    .desc_count        (desc_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] desc_word(input int unsigned base, input int unsigned len,
                                            input int unsigned stride, input int unsigned rows);
    return (64'(rows % 4096) << 39) | (64'(stride % 8192) << 26) |
           (64'(len % 8192) << 13) | 64'(base % 8192);
  endfunction

  // Row i of a tile sits at base + i*stride, modulo the 13-bit address space.
  function automatic logic [63:0] row_word(input int unsigned base, input int unsigned stride,
                                           input int unsigned len, input int unsigned i);
    int unsigned a;
    a = (base + i * stride) % 8192;
    return (64'(a) << 13) | 64'(len);
  endfunction

  // mode: 0 = tready always high, 1 = tready 1010..., 2 = random tready.
  // abort_after >= 0 returns (with the tile still in flight) after that many rows.
  task automatic run_desc(input int unsigned base, input int unsigned len,
                          input int unsigned stride, input int unsigned rows,
                          input int mode, input int abort_after);
    int   n;
    int   cyc;
    int unsigned i;
    logic rdy;
    @(negedge clk);
    s_desc_tdata  = desc_word(base, len, stride, rows);
    s_desc_tvalid = 1'b1;
    n = 0;
    while (!s_desc_tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("desc_tready_wait", s_desc_tready, 1);
    if (!s_desc_tready) begin
      s_desc_tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    s_desc_tvalid = 1'b0;
    mdl_desc++;
    check_eq("desc_tready_drop", s_desc_tready, 0);
    if (rows == 0 || len == 0) begin
      m_instruct_tready = 1'b1;
      check_eq("empty_done", done, 1);
      check_eq("empty_tvalid", m_instruct_tvalid, 0);
      check_eq("empty_busy", busy, 0);
      @(negedge clk);
      check_eq("empty_done_clear", done, 0);
      check_eq("empty_tvalid_after", m_instruct_tvalid, 0);
      check_eq("empty_tready_back", s_desc_tready, 1);
      return;
    end
    i   = 0;
    cyc = 0;
    while (i < rows && cyc < 20 * int'(rows) + 20) begin
      if (abort_after >= 0 && i == abort_after) return;
      check_eq("row_tvalid", m_instruct_tvalid, 1);
      check_eq("row_tdata", m_instruct_tdata, row_word(base, stride, len, i));
      check_eq("row_busy", busy, 1);
      check_eq("row_no_done", done, 0);
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 2 == 0);
      else                rdy = ($urandom_range(0, 2) != 0);
      m_instruct_tready = rdy;
      @(negedge clk);
      if (rdy) begin
        i++;
        mdl_instr++;
      end
      cyc++;
    end
    check_eq("row_budget", 64'(i), 64'(rows));
    m_instruct_tready = 1'($urandom_range(0, 1));
    check_eq("last_tvalid_drop", m_instruct_tvalid, 0);
    check_eq("last_done", done, 1);
    check_eq("last_busy", busy, 0);
    check_eq("last_tready_low", s_desc_tready, 0);
    @(negedge clk);
    check_eq("done_pulse_end", done, 0);
    check_eq("idle_tvalid", m_instruct_tvalid, 0);
    check_eq("idle_tready_back", s_desc_tready, 1);
  endtask

`ifdef BRAM_INSTR_GEN_STATS_EN
  task automatic check_stats(input string tag_d, input string tag_i);
    check_eq(tag_d, desc_count, 64'(mdl_desc));
    check_eq(tag_i, instr_count, 64'(mdl_instr));
  endtask
`endif

  initial begin
    rst_n             = 1'b0;
    s_desc_tdata      = '0;
    s_desc_tvalid     = 1'b0;
    m_instruct_tready = 1'b0;
    #12;
    check_eq("rst_tready", s_desc_tready, 1);
    check_eq("rst_tvalid", m_instruct_tvalid, 0);
    check_eq("rst_tdata", m_instruct_tdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_desc(13'h010, 64, 128, 4, 0, -1);
    run_desc(13'h010, 64, 128, 4, 1, -1);
    run_desc(13'h1FF0, 16, 13'h20, 2, 0, -1);
    run_desc(13'h020, 8, 4, 0, 0, -1);
    run_desc(13'h020, 0, 4, 3, 0, -1);
    run_desc(13'h123, 8191, 0, 3, 2, -1);

    // Reset in the middle of an 8-row tile, after two rows went out.
    run_desc(13'h100, 16, 3, 8, 0, 2);
    m_instruct_tready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tvalid", m_instruct_tvalid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_tready", s_desc_tready, 1);
    check_eq("midrst_tdata", m_instruct_tdata, 0);
    mdl_desc  = 0;
    mdl_instr = 0;
    @(negedge clk);
    rst_n = 1'b1;

    run_desc(13'h055, 32, 7, 3, 0, -1);
    run_desc(13'h200, 32, 7, 0, 0, -1);
    run_desc(13'h1FFE, 5, 13'h1000, 5, 2, -1);
`ifdef BRAM_INSTR_GEN_STATS_EN
    check_eq("stats_desc3", desc_count, 3);
    check_eq("stats_instr8", instr_count, 8);
`endif

    for (int k = 0; k < 25; k++) begin
      run_desc($urandom_range(0, 8191),
               ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 8191),
               $urandom_range(0, 8191), $urandom_range(0, 6), 2, -1);
    end
`ifdef BRAM_INSTR_GEN_STATS_EN
    check_stats("stats_desc_final", "stats_instr_final");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
